// File: rtl/compact_pkg.sv
// Shared constants and types for the compression datapath banyan stage.
//   N  : lane count (banyan port count)
//   W  : payload width per lane
//   TW : routing-tag width, log2(N)
//   tagged_word_t : {tag, payload} as presented to the banyan
//   get_tag()     : extracts the routing tag from a banyan word
package compact_pkg;

   localparam int unsigned N  = 8;
   localparam int unsigned W  = 32;
   localparam int unsigned TW = $clog2(N);

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [W-1:0]  payload;
   } tagged_word_t;

   function automatic logic [TW-1:0] get_tag(input tagged_word_t word);
      return word.tag;
   endfunction

endpackage

// File: rtl/prefix_popcount.sv
// Combinational exclusive prefix popcount.
//   vec_i   : N-bit input vector
//   pre_o   : pre_o[i] = number of set bits in vec_i[i-1:0] (pre_o[0] = 0)
//   total_o : number of set bits in vec_i, 0..N
module prefix_popcount
   import compact_pkg::*;
(
   input  logic [N-1:0]         vec_i,
   output logic [N-1:0][TW-1:0] pre_o,
   output logic [TW:0]          total_o
);

   logic [TW:0] acc;

   always_comb begin
      acc   = '0;
      pre_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         // Exclusive prefix never exceeds N-1, so TW bits suffice.
         pre_o[i] = acc[TW-1:0];
         acc      = acc + (TW+1)'(vec_i[i]);
      end
      total_o = acc;
   end

endmodule

// File: rtl/banyan_tagger.sv
// Routing-tag generator ahead of the N-port banyan. Each valid lane gets
// destination (base + exclusive prefix count) mod N in the top TW bits, so the
// banyan scatters words into consecutive wrap-around lanes. The base persists
// across beats so successive beats pack contiguously.
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid/ready : input handshake
//   in_sop         : first beat of a frame, tags from base 0
//   in_lane_vld    : per-lane valid
//   in_data        : per-lane payload
//   out_valid/ready: output handshake (registered, 1-cycle latency)
//   out_lane_vld   : per-lane valid for the banyan
//   out_data       : per-lane {tag, payload}, zero for invalid lanes
//   out_base       : base used for this beat
//   out_count      : number of valid lanes in this beat
module banyan_tagger
   import compact_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sop,
   input  logic [N-1:0]       in_lane_vld,
   input  logic [W-1:0]       in_data [N-1:0],
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_lane_vld,
   output tagged_word_t       out_data [N-1:0],
   output logic [TW-1:0]      out_base,
   output logic [TW:0]        out_count
);

   logic [N-1:0][TW-1:0] pre;
   logic [TW:0]          total;
   logic [TW-1:0]        eb;
   logic                 in_xfer;
   logic                 out_xfer;

   logic [TW-1:0] base_d, base_q;
   logic          valid_d, valid_q;
   logic [N-1:0]  lane_vld_d, lane_vld_q;
   tagged_word_t  data_d [N-1:0];
   tagged_word_t  data_q [N-1:0];
   logic [TW-1:0] obase_d, obase_q;
   logic [TW:0]   count_d, count_q;

   prefix_popcount u_prefix_popcount (
      .vec_i   (in_lane_vld),
      .pre_o   (pre),
      .total_o (total)
   );

   assign in_ready = !valid_q || out_ready;

   always_comb begin
      eb       = in_sop ? '0 : base_q;
      in_xfer  = in_valid && in_ready;
      out_xfer = valid_q && out_ready;

      base_d     = base_q;
      valid_d    = valid_q;
      lane_vld_d = lane_vld_q;
      data_d     = data_q;
      obase_d    = obase_q;
      count_d    = count_q;

      // Count of N wraps to zero in TW bits, leaving the base unchanged.
      if (in_xfer) begin
         base_d = eb + total[TW-1:0];
      end

      if (in_xfer && (total != '0)) begin
         valid_d    = 1'b1;
         lane_vld_d = in_lane_vld;
         obase_d    = eb;
         count_d    = total;
         for (int unsigned i = 0; i < N; i++) begin
            if (in_lane_vld[i]) begin
               data_d[i].tag     = eb + pre[i];
               data_d[i].payload = in_data[i];
            end else begin
               data_d[i] = '0;
            end
         end
      end else if (out_xfer) begin
         // Drained with nothing new (including an empty beat): clear.
         valid_d    = 1'b0;
         lane_vld_d = '0;
         obase_d    = '0;
         count_d    = '0;
         for (int unsigned i = 0; i < N; i++) begin
            data_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q     <= '0;
         valid_q    <= 1'b0;
         lane_vld_q <= '0;
         obase_q    <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         base_q     <= base_d;
         valid_q    <= valid_d;
         lane_vld_q <= lane_vld_d;
         obase_q    <= obase_d;
         count_q    <= count_d;
         for (int unsigned i = 0; i < N; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign out_valid    = valid_q;
   assign out_lane_vld = lane_vld_q;
   assign out_data     = data_q;
   assign out_base     = obase_q;
   assign out_count    = count_q;

endmodule

// File: tb/tb_banyan_tagger.sv
module tb_banyan_tagger;
   import compact_pkg::*;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_sop;
   logic [N-1:0]       in_lane_vld;
   logic [W-1:0]       in_data [N-1:0];
   logic               out_valid;
   logic               out_ready;
   logic [N-1:0]       out_lane_vld;
   tagged_word_t       out_data [N-1:0];
   logic [TW-1:0]      out_base;
   logic [TW:0]        out_count;

   int n_checks = 0;
   int n_fail   = 0;

   banyan_tagger dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sop       (in_sop),
      .in_lane_vld  (in_lane_vld),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_lane_vld (out_lane_vld),
      .out_data     (out_data),
      .out_base     (out_base),
      .out_count    (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic                 sop;
      logic [N-1:0]         vld;
      logic                 ov;
      logic [TW-1:0]        base;
      logic [TW:0]          cnt;
      logic [N-1:0][TW-1:0] tags;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] payload(input int k, input int i);
      return 32'hC0DE_0000 | (k << 4) | i;
   endfunction

   task automatic drive(input logic sop, input logic [N-1:0] vld, input int k);
      in_valid    = 1'b1;
      in_sop      = sop;
      in_lane_vld = vld;
      for (int i = 0; i < N; i++) in_data[i] = payload(k, i);
   endtask

   // Compare every lane against {tag, payload(k,i)} for valid lanes, 0 otherwise.
   task automatic check_lanes(input string name, input logic [N-1:0] vld,
                              input logic [N-1:0][TW-1:0] tags, input int k);
      tagged_word_t e;
      for (int i = 0; i < N; i++) begin
         e = '0;
         if (vld[i]) begin
            e.tag     = tags[i];
            e.payload = payload(k, i);
         end
         check($sformatf("%s_lane%0d", name, i), 64'(out_data[i]), 64'(e));
         if (vld[i]) check($sformatf("%s_tag%0d", name, i), 64'(get_tag(out_data[i])),
                           64'(tags[i]));
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'hA5, 1'b1, 3'd0, 4'd4,
                  {3'd3, 3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0}};
      vecs[1] = '{1'b0, 8'hFF, 1'b1, 3'd4, 4'd8,
                  {3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4}};
      vecs[2] = '{1'b0, 8'h03, 1'b1, 3'd4, 4'd2,
                  {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd4}};
      vecs[3] = '{1'b0, 8'h07, 1'b1, 3'd6, 4'd3,
                  {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6}};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 3'd0, 4'd0, '0};
      vecs[5] = '{1'b0, 8'h80, 1'b1, 3'd1, 4'd1,
                  {3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
      vecs[6] = '{1'b1, 8'h00, 1'b0, 3'd0, 4'd0, '0};
      vecs[7] = '{1'b0, 8'h40, 1'b1, 3'd0, 4'd1, '0};
      vecs[8] = '{1'b1, 8'h18, 1'b1, 3'd0, 4'd2,
                  {3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0}};
      vecs[9] = '{1'b0, 8'hFE, 1'b1, 3'd2, 4'd7,
                  {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0}};

      rst = 1'b1;
      in_valid = 1'b0;
      in_sop = 1'b0;
      in_lane_vld = '0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) in_data[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_base", 64'(out_base), 64'd0);
      check("rst_count", 64'(out_count), 64'd0);
      check("rst_lane_vld", 64'(out_lane_vld), 64'd0);

      // Table-driven beats, out_ready held high.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive(vecs[k].sop, vecs[k].vld, k);
         check($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].ov));
         check($sformatf("v%0d_base", k), 64'(out_base), 64'(vecs[k].base));
         check($sformatf("v%0d_count", k), 64'(out_count), 64'(vecs[k].cnt));
         check($sformatf("v%0d_lane_vld", k), 64'(out_lane_vld), 64'(vecs[k].vld));
         check_lanes($sformatf("v%0d", k), vecs[k].vld, vecs[k].tags, k);
      end

      // Drain; base is now 1.
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("drain_out_valid", 64'(out_valid), 64'd0);

      // Backpressure: beat A (base 1) pending, beat B offered while stalled.
      @(negedge clk);
      out_ready = 1'b0;
      drive(1'b0, 8'h0F, 20);
      @(posedge clk);
      #1;
      check("bp_a_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      drive(1'b0, 8'h30, 21);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
         check($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
         check($sformatf("bp_base_c%0d", c), 64'(out_base), 64'd1);
         check($sformatf("bp_count_c%0d", c), 64'(out_count), 64'd4);
         check_lanes($sformatf("bp_a_c%0d", c), 8'h0F,
                     {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, 20);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      check("bp_b_valid", 64'(out_valid), 64'd1);
      check("bp_b_base", 64'(out_base), 64'd5);
      check("bp_b_count", 64'(out_count), 64'd2);
      check_lanes("bp_b", 8'h30, {3'd0, 3'd0, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0}, 21);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_drain_valid", 64'(out_valid), 64'd0);

      // Base now 7; beat C leaves base 5 and stays pending, then async reset.
      @(negedge clk);
      out_ready = 1'b0;
      drive(1'b0, 8'h3F, 30);
      @(posedge clk);
      #1;
      check("rc_c_valid", 64'(out_valid), 64'd1);
      check("rc_c_base", 64'(out_base), 64'd7);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rc_out_valid", 64'(out_valid), 64'd0);
      check("rc_base", 64'(out_base), 64'd0);
      check("rc_count", 64'(out_count), 64'd0);
      check("rc_lane_vld", 64'(out_lane_vld), 64'd0);
      check_lanes("rc", 8'h00, '0, 0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h06, 31);
      @(posedge clk);
      #1;
      check("rc_d_valid", 64'(out_valid), 64'd1);
      check("rc_d_base", 64'(out_base), 64'd0);
      check_lanes("rc_d", 8'h06, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0}, 31);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/banyan_tagger.md
# banyan_tagger

Routing-tag generator directly upstream of the 8-port banyan network in the compression datapath. Each input beat carries up to N 32-bit words with per-lane valids. The block computes each valid lane's destination, (running base + exclusive prefix count of valid lanes below it) mod N, and writes it into the top TW bits of the word. The banyan then scatters the words into consecutive, wrap-around output lanes without conflict. The output is registered, with valid/ready backpressure, and the running base is kept across beats so that successive beats pack contiguously.

## Interface
- N, 8, lane count; power of two; matches the banyan port count
- W, 32, payload width per lane
- TW, $clog2(N) = 3, routing-tag width; banyan word width is W+TW
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat this cycle
- in_sop  input  1  first beat of a frame; base is forced to 0 before tagging this beat
- in_lane_vld  input  N  per-lane word valid
- in_data  input  W x N (unpacked [N-1:0])  per-lane payload
- out_valid  output  1  tagged beat present (at least one lane valid)
- out_ready  input  1  downstream (banyan + packer) accepts the beat
- out_lane_vld  output  N  per-lane valid, wired to the banyan i_valid
- out_data  output  (W+TW) x N  {tag[TW-1:0], payload}; tag MSB is bit W+TW-1 (consumed by the last banyan stage), tag LSB is bit W (consumed by the first stage)
- out_base  output  TW  base used for this beat (destination of its lowest valid lane)
- out_count  output  TW+1  popcount of out_lane_vld, 0..N

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational from registered state and out_ready.
- Per lane i: pre[i] = popcount(in_lane_vld[i-1:0]), with pre[0] = 0.
- Effective base: eb = in_sop ? 0 : base_q.
- Tag[i] = (eb + pre[i]) mod N, computed TW bits wide with natural wrap.
- Invalid lanes: out_data lane = 0 and tag = 0; out_lane_vld bit = 0.
- The base register updates only on an input transfer: base_q <= (eb + popcount(in_lane_vld)) mod N.
- A count of N leaves the base unchanged. A sop beat with count c sets the base to c mod N.
- Empty beat (in_lane_vld == 0):
  - Accepted and consumed; it produces no output beat.
  - The output register is cleared if it was being drained, else it holds.
  - in_sop on an empty beat still sets base_q to 0.
- Holding rule: while out_valid && !out_ready, all out_* stay stable and base_q is frozen.
- Tag assignment keeps source order monotone and destinations cyclically consecutive. This is the conflict-free pattern for the banyan; the block does not check for conflicts.

## Timing
- Latency: 1 cycle, from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready stays high.
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid = 0, out_lane_vld = 0, out_data = 0, out_base = 0, out_count = 0.
  - base_q = 0; in_ready = 1 after reset deasserts.
- Reset mid-frame: the pending output beat is discarded and the base returns to 0. The next beat tags from 0 whether or not in_sop is set.
- Input transfer and output transfer in the same cycle: the output register loads the new beat, with no bubble.
- Input offered while stalled (out_ready = 0): in_ready = 0 and nothing is sampled.

## Structure
- Shared package compact_pkg holds:
  - the N, W and TW constants
  - typedef tagged_word_t = struct packed {tag, payload}
  - a function for tag extraction, reused by the banyan bench
- One sub-module, prefix_popcount: combinational, N-bit vector in, N exclusive prefix counts plus the total out.
- Top level: tag adders, base register, output register, and handshake.

## Test plan
- Beat 1 with sop, lane_vld = 8'b1010_0101 → tags lanes 0,2,5,7 = 0,1,2,3; out_count = 4, out_base = 0. Beat 2 with lane_vld = 8'hFF → tags lanes 0..7 = 4,5,6,7,0,1,2,3; out_base = 4, next base 4.
- Wrap: base 6, lane_vld = 8'b0000_0111 → tags 6,7,0; next base 1.
- Empty beat: lane_vld = 0 with no sop → no out_valid, base unchanged. The same beat with sop → base becomes 0.
- Backpressure: hold out_ready = 0 for 3 cycles with a beat pending → out_* stable, in_ready = 0, base frozen. Release → both beats emerge in order with correct tags.
- Reset asserted with base 5 and a beat pending → out_valid drops immediately (asynchronous), all outputs 0. The next beat without sop tags from 0.
- End-to-end: connect to the banyan and drive 1000 random beats → every valid word lands at its tagged lane. Across beats, output words form a contiguous cyclic sequence with no lane collisions.
